// File: rtl/dmem_seq_if.sv
// dmem_seq_if: command and memory-tile bus for the data-memory address sequencer.
//
// Signals:
//   cmd_valid/cmd_ready   command handshake (accept when both are high on a rising clk edge)
//   cmd_op                00 NOP, 01 LOAD, 10 STORE, 11 STREAM
//   cmd_port              LOAD/STORE route: 0 vertical, 1 horizontal
//   cmd_raddr/cmd_waddr   read/write start addresses
//   cmd_len               word count N (AddrDMEM+1 bits, so a full sweep fits)
//   stall                 freeze the current access this cycle
//   r_addr/w_addr         memory read/write addresses
//   we_ram                memory write enable
//   sel_ram_i/sel_ram_o   write/read data routes: 00 none, 10 vertical, 11 horizontal
//   busy/done             sequencer status; done is a one-cycle completion pulse
//
// Modports: master = command issuer / memory tile side, slave = sequencer.
interface dmem_seq_if #(
  parameter int unsigned AddrDMEM = 8,
  parameter int unsigned LenW     = AddrDMEM + 1
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic                cmd_port;
  logic [AddrDMEM-1:0] cmd_raddr;
  logic [AddrDMEM-1:0] cmd_waddr;
  logic [LenW-1:0]     cmd_len;
  logic                stall;
  logic [AddrDMEM-1:0] r_addr;
  logic [AddrDMEM-1:0] w_addr;
  logic                we_ram;
  logic [1:0]          sel_ram_i;
  logic [1:0]          sel_ram_o;
  logic                busy;
  logic                done;

  modport master (
    output cmd_valid, cmd_op, cmd_port, cmd_raddr, cmd_waddr, cmd_len, stall,
    input  cmd_ready, r_addr, w_addr, we_ram, sel_ram_i, sel_ram_o, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_port, cmd_raddr, cmd_waddr, cmd_len, stall,
    output cmd_ready, r_addr, w_addr, we_ram, sel_ram_i, sel_ram_o, busy, done
  );
endinterface

// File: rtl/dmem_seq.sv
// dmem_seq: command-driven address sequencer for the data memory tile.
//
// Accepts one block-transfer command at a time (LOAD, STORE, STREAM or NOP), then streams
// N consecutive addresses with wrap-around, pausing while stall is high, and pulses done
// for one cycle on completion.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   dmem_seq_if slave modport (command handshake, stall, memory addresses/controls)
//
// All outputs decode from registered state except we_ram, which also gates on stall so a
// stalled cycle never commits a write.
module dmem_seq #(
  parameter int unsigned AddrDMEM = 8,
  parameter int unsigned LenW     = AddrDMEM + 1
) (
  input logic       clk,
  input logic       rst,
  dmem_seq_if.slave bus
);

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpLoad   = 2'b01,
    OpStore  = 2'b10,
    OpStream = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e              state_q;
  op_e                 op_q;
  logic                port_q;
  logic [AddrDMEM-1:0] raddr_q;
  logic [AddrDMEM-1:0] waddr_q;
  logic [LenW-1:0]     remaining_q;

  op_e  cmd_op;
  logic cmd_starts_run;
  logic r_active;
  logic w_active;

  assign cmd_op = op_e'(bus.cmd_op);
  // Zero-length and NOP commands skip RUN entirely and go straight to the done pulse.
  assign cmd_starts_run = (cmd_op != OpNop) && (bus.cmd_len != '0);

  // Which counters the latched op uses; only these advance.
  assign r_active = (op_q == OpStore) || (op_q == OpStream);
  assign w_active = (op_q == OpLoad) || (op_q == OpStream);

  // State, command fields and address counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      port_q      <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            op_q        <= cmd_op;
            port_q      <= bus.cmd_port;
            remaining_q <= bus.cmd_len;
            if (cmd_starts_run) begin
              // Counters load only when an access will happen, so addresses hold otherwise.
              raddr_q <= bus.cmd_raddr;
              waddr_q <= bus.cmd_waddr;
              state_q <= StRun;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          if (!bus.stall) begin
            // Counters wrap naturally at 2**AddrDMEM.
            if (r_active) raddr_q <= raddr_q + AddrDMEM'(1);
            if (w_active) waddr_q <= waddr_q + AddrDMEM'(1);
            remaining_q <= remaining_q - LenW'(1);
            if (remaining_q == LenW'(1)) state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  logic run;
  assign run = (state_q == StRun);

  // Output decode.
  always_comb begin
    bus.sel_ram_i = 2'b00;
    bus.sel_ram_o = 2'b00;
    if (run) begin
      unique case (op_q)
        OpLoad:   bus.sel_ram_i = {1'b1, port_q};
        OpStore:  bus.sel_ram_o = {1'b1, port_q};
        OpStream: begin
          bus.sel_ram_i = 2'b10;
          bus.sel_ram_o = 2'b11;
        end
        default: begin
          bus.sel_ram_i = 2'b00;
          bus.sel_ram_o = 2'b00;
        end
      endcase
    end
  end

  assign bus.we_ram    = run && w_active && !bus.stall;
  assign bus.r_addr    = raddr_q;
  assign bus.w_addr    = waddr_q;
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q == StRun) || (state_q == StDone);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_dmem_seq.sv
module tb_dmem_seq;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  dmem_seq_if #(.AddrDMEM(8)) bus ();

  dmem_seq #(.AddrDMEM(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one edge; returns #1 after the accepting edge (first cycle after accept).
  task automatic send(input logic [1:0] op, input logic port, input logic [7:0] ra,
                      input logic [7:0] wa, input logic [8:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_port  = port;
    bus.cmd_raddr = ra;
    bus.cmd_waddr = wa;
    bus.cmd_len   = len;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset values.
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL por_ready got %b exp 1", bus.cmd_ready); end
    tests++; if (bus.r_addr !== 8'h00 || bus.w_addr !== 8'h00) begin fails++; $display("FAIL por_addr got %h/%h exp 00/00", bus.r_addr, bus.w_addr); end
    tests++; if (bus.we_ram !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL por_ctl got we%b busy%b done%b exp 000", bus.we_ram, bus.busy, bus.done); end
    tests++; if (bus.sel_ram_i !== 2'b00 || bus.sel_ram_o !== 2'b00) begin fails++; $display("FAIL por_sel got %b/%b exp 00/00", bus.sel_ram_i, bus.sel_ram_o); end
    #2 rst = 1'b1;
    step();
    // Mid-RUN reset: LOAD N=8, abort after three words.
    send(2'b01, 1'b0, 8'h00, 8'h30, 9'd8);
    for (int i = 0; i < 3; i++) step();
    tests++; if (bus.w_addr !== 8'h33 || bus.we_ram !== 1'b1) begin fails++; $display("FAIL rst_pre got w%h we%b exp 33/1", bus.w_addr, bus.we_ram); end
    #2 rst = 1'b0;
    #1;
    tests++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.we_ram !== 1'b0) begin fails++; $display("FAIL rst_async got ready%b busy%b we%b exp 1 0 0", bus.cmd_ready, bus.busy, bus.we_ram); end
    tests++; if (bus.sel_ram_i !== 2'b00 || bus.sel_ram_o !== 2'b00) begin fails++; $display("FAIL rst_sel got %b/%b exp 00/00", bus.sel_ram_i, bus.sel_ram_o); end
    tests++; if (bus.r_addr !== 8'h00 || bus.w_addr !== 8'h00) begin fails++; $display("FAIL rst_addr got %h/%h exp 00/00", bus.r_addr, bus.w_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.we_ram !== 1'b0 || bus.w_addr !== 8'h00) begin fails++; $display("FAIL rst_hold cyc%0d got we%b w%h exp 0/00", i, bus.we_ram, bus.w_addr); end
    end
    #2 rst = 1'b1;
    step();
    // Stays idle after release with no command offered.
    step();
    tests++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL rst_release got ready%b done%b exp 1 0", bus.cmd_ready, bus.done); end
  endtask

  task automatic test_load();
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL load_ready_pre got %b exp 1", bus.cmd_ready); end
    send(2'b01, 1'b1, 8'h00, 8'h10, 9'd4);
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.we_ram !== 1'b1 || bus.sel_ram_i !== 2'b11 || bus.sel_ram_o !== 2'b00) begin fails++; $display("FAIL load_ctl cyc%0d got we%b si%b so%b exp 1 11 00", i + 1, bus.we_ram, bus.sel_ram_i, bus.sel_ram_o); end
      tests++; if (bus.w_addr !== 8'h10 + 8'(i)) begin fails++; $display("FAIL load_waddr cyc%0d got %h exp %h", i + 1, bus.w_addr, 8'h10 + 8'(i)); end
      step();
    end
    tests++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.we_ram !== 1'b0) begin fails++; $display("FAIL load_done got done%b ready%b we%b exp 1 0 0", bus.done, bus.cmd_ready, bus.we_ram); end
    step();
    tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL load_ready got done%b ready%b busy%b exp 0 1 0", bus.done, bus.cmd_ready, bus.busy); end
    tests++; if (bus.w_addr !== 8'h14) begin fails++; $display("FAIL load_hold got %h exp 14", bus.w_addr); end
  endtask

  task automatic test_store();
    logic [7:0] exp_r [4];
    exp_r = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    send(2'b10, 1'b0, 8'hFE, 8'h00, 9'd4);
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.r_addr !== exp_r[i]) begin fails++; $display("FAIL store_raddr cyc%0d got %h exp %h", i + 1, bus.r_addr, exp_r[i]); end
      tests++; if (bus.sel_ram_o !== 2'b10 || bus.sel_ram_i !== 2'b00 || bus.we_ram !== 1'b0) begin fails++; $display("FAIL store_ctl cyc%0d got so%b si%b we%b exp 10 00 0", i + 1, bus.sel_ram_o, bus.sel_ram_i, bus.we_ram); end
      step();
    end
    tests++; if (bus.done !== 1'b1 || bus.we_ram !== 1'b0) begin fails++; $display("FAIL store_done got done%b we%b exp 1 0", bus.done, bus.we_ram); end
    step();
  endtask

  task automatic test_stream_stall();
    logic [7:0] exp_r [4];
    logic [7:0] exp_w [4];
    logic       exp_we [4];
    logic       stl [4];
    exp_r  = '{8'h20, 8'h21, 8'h21, 8'h22};
    exp_w  = '{8'h40, 8'h41, 8'h41, 8'h42};
    exp_we = '{1'b1, 1'b0, 1'b1, 1'b1};
    stl    = '{1'b0, 1'b1, 1'b0, 1'b0};
    send(2'b11, 1'b0, 8'h20, 8'h40, 9'd3);
    for (int i = 0; i < 4; i++) begin
      bus.stall = stl[i];
      #1;
      tests++; if (bus.r_addr !== exp_r[i] || bus.w_addr !== exp_w[i]) begin fails++; $display("FAIL stream_addr cyc%0d got %h/%h exp %h/%h", i + 1, bus.r_addr, bus.w_addr, exp_r[i], exp_w[i]); end
      tests++; if (bus.we_ram !== exp_we[i] || bus.sel_ram_i !== 2'b10 || bus.sel_ram_o !== 2'b11) begin fails++; $display("FAIL stream_ctl cyc%0d got we%b si%b so%b exp %b 10 11", i + 1, bus.we_ram, bus.sel_ram_i, bus.sel_ram_o, exp_we[i]); end
      step();
      bus.stall = 1'b0;
    end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stream_done cyc5 got %b exp 1", bus.done); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_done  [9];
    logic exp_ready [9];
    int   pulses;
    exp_done  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_ready = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pulses = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_port  = 1'b1;
    bus.cmd_raddr = 8'h55;
    bus.cmd_waddr = 8'h66;
    bus.cmd_len   = 9'd5;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) begin bus.cmd_op = 2'b01; bus.cmd_len = 9'd0; end
      if (c == 4) begin bus.cmd_op = 2'b10; bus.cmd_port = 1'b0; bus.cmd_len = 9'd1; end
      if (c == 5) bus.cmd_valid = 1'b0;
      #1;
      if (bus.done === 1'b1) pulses++;
      tests++; if (bus.done !== exp_done[c] || bus.cmd_ready !== exp_ready[c]) begin fails++; $display("FAIL b2b_hs cyc%0d got done%b ready%b exp %b %b", c, bus.done, bus.cmd_ready, exp_done[c], exp_ready[c]); end
      tests++; if (bus.we_ram !== 1'b0 || bus.sel_ram_i !== 2'b00) begin fails++; $display("FAIL b2b_nowrite cyc%0d got we%b si%b exp 0 00", c, bus.we_ram, bus.sel_ram_i); end
      if (c == 5) begin
        tests++; if (bus.sel_ram_o !== 2'b10 || bus.r_addr !== 8'h55) begin fails++; $display("FAIL b2b_store got so%b r%h exp 10 55", bus.sel_ram_o, bus.r_addr); end
      end else begin
        tests++; if (bus.sel_ram_o !== 2'b00) begin fails++; $display("FAIL b2b_sel cyc%0d got so%b exp 00", c, bus.sel_ram_o); end
      end
      step();
    end
    tests++; if (pulses != 3) begin fails++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
  endtask

  task automatic test_full_sweep();
    int         writes;
    int         addr_err;
    int         pulses;
    logic [7:0] last_w;
    writes = 0; addr_err = 0; pulses = 0; last_w = 8'h00;
    send(2'b01, 1'b0, 8'h00, 8'h80, 9'd256);
    for (int i = 0; i < 256; i++) begin
      if (bus.we_ram === 1'b1) begin
        writes++;
        last_w = bus.w_addr;
      end
      if (bus.w_addr !== 8'(8'h80 + i)) addr_err++;
      if (bus.done === 1'b1) pulses++;
      step();
    end
    tests++; if (writes != 256) begin fails++; $display("FAIL sweep_writes got %0d exp 256", writes); end
    tests++; if (addr_err != 0) begin fails++; $display("FAIL sweep_addr_errs got %0d exp 0", addr_err); end
    tests++; if (last_w !== 8'h7F) begin fails++; $display("FAIL sweep_last got %h exp 7f", last_w); end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        tests++; if (bus.done !== 1'b1 || bus.we_ram !== 1'b0) begin fails++; $display("FAIL sweep_done got done%b we%b exp 1 0", bus.done, bus.we_ram); end
      end
      if (bus.done === 1'b1) pulses++;
      step();
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL sweep_pulses got %0d exp 1", pulses); end
    tests++; if (bus.cmd_ready !== 1'b1 || bus.w_addr !== 8'h80) begin fails++; $display("FAIL sweep_idle got ready%b w%h exp 1 80", bus.cmd_ready, bus.w_addr); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_port  = 1'b0;
    bus.cmd_raddr = 8'h00;
    bus.cmd_waddr = 8'h00;
    bus.cmd_len   = 9'd0;
    bus.stall     = 1'b0;
    #3;
    test_reset();
    test_load();
    test_store();
    test_stream_stall();
    test_back_to_back();
    test_full_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
